// File: rtl/decode_if.sv
// decode_if: bundle between an instruction source and decode.
// master drives addr/instr; slave returns fields, text, imm, flags.
interface decode_if;
  logic [63:0] addr;
  logic [31:0] instr;
  string       decoded_instr;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        illegal;
  logic [15:0] illegal_cnt;

  modport master (
    output addr, instr,
    input  decoded_instr, rd, rs1, rs2, imm,
    input  opcode, funct3, funct7,
    input  illegal, illegal_cnt
  );

  modport slave (
    input  addr, instr,
    output decoded_instr, rd, rs1, rs2, imm,
    output opcode, funct3, funct7,
    output illegal, illegal_cnt
  );
endinterface

// File: rtl/decode.sv
// decode: combinational RV64IM field/imm/disassembly decoder
// plus a saturating registered count of non-zero illegal words.
module decode (
  input  logic   clk,
  input  logic   reset,
  decode_if.slave bus
);
  localparam logic [3:0] K_NONE = 4'd0;
  localparam logic [3:0] K_R    = 4'd1;
  localparam logic [3:0] K_I    = 4'd2;
  localparam logic [3:0] K_SH   = 4'd3;
  localparam logic [3:0] K_SHW  = 4'd4;
  localparam logic [3:0] K_LD   = 4'd5;
  localparam logic [3:0] K_ST   = 4'd6;
  localparam logic [3:0] K_U    = 4'd7;
  localparam logic [3:0] K_B    = 4'd8;
  localparam logic [3:0] K_J    = 4'd9;

  logic [31:0] w_in;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  string       w_mn;
  logic [3:0]  w_kind;
  logic [31:0] w_imm;
  logic [63:0] w_tgt;
  logic [15:0] r_cnt;

  assign w_in = bus.instr;
  assign w_f3 = w_in[14:12];
  assign w_f7 = w_in[31:25];

  assign bus.opcode = w_in[6:0];
  assign bus.rd     = w_in[11:7];
  assign bus.funct3 = w_f3;
  assign bus.rs1    = w_in[19:15];
  assign bus.rs2    = w_in[24:20];
  assign bus.funct7 = w_f7;
  assign bus.imm    = w_imm;
  assign bus.illegal     = (w_kind == K_NONE);
  assign bus.illegal_cnt = r_cnt;

  function automatic string rn(input logic [4:0] i);
    int n;
    n = int'(i);
    if (n == 0)       return "zero";
    else if (n == 1)  return "ra";
    else if (n == 2)  return "sp";
    else if (n == 3)  return "gp";
    else if (n == 4)  return "tp";
    else if (n < 8)   return $sformatf("t%0d", n - 5);
    else if (n < 10)  return $sformatf("s%0d", n - 8);
    else if (n < 18)  return $sformatf("a%0d", n - 10);
    else if (n < 28)  return $sformatf("s%0d", n - 16);
    else              return $sformatf("t%0d", n - 25);
  endfunction

  always_comb begin
    w_mn   = "";
    w_kind = K_NONE;
    case (w_in[6:0])
      7'b0110111: begin w_mn = "lui";   w_kind = K_U; end
      7'b0010111: begin w_mn = "auipc"; w_kind = K_U; end
      7'b1101111: begin w_mn = "jal";   w_kind = K_J; end
      7'b1100111: begin
        w_kind = K_LD;
        if (w_f3 == 3'd0) w_mn = "jalr";
      end
      7'b1100011: begin
        w_kind = K_B;
        case (w_f3)
          3'd0: w_mn = "beq";
          3'd1: w_mn = "bne";
          3'd4: w_mn = "blt";
          3'd5: w_mn = "bge";
          3'd6: w_mn = "bltu";
          3'd7: w_mn = "bgeu";
          default: w_mn = "";
        endcase
      end
      7'b0000011: begin
        w_kind = K_LD;
        case (w_f3)
          3'd0: w_mn = "lb";
          3'd1: w_mn = "lh";
          3'd2: w_mn = "lw";
          3'd3: w_mn = "ld";
          3'd4: w_mn = "lbu";
          3'd5: w_mn = "lhu";
          3'd6: w_mn = "lwu";
          default: w_mn = "";
        endcase
      end
      7'b0100011: begin
        w_kind = K_ST;
        case (w_f3)
          3'd0: w_mn = "sb";
          3'd1: w_mn = "sh";
          3'd2: w_mn = "sw";
          3'd3: w_mn = "sd";
          default: w_mn = "";
        endcase
      end
      7'b0010011: begin
        w_kind = K_I;
        case (w_f3)
          3'd0: w_mn = "addi";
          3'd2: w_mn = "slti";
          3'd3: w_mn = "sltiu";
          3'd4: w_mn = "xori";
          3'd6: w_mn = "ori";
          3'd7: w_mn = "andi";
          3'd1: begin
            w_kind = K_SH;
            if (w_in[31:26] == 6'b000000) w_mn = "slli";
          end
          default: begin
            w_kind = K_SH;
            if (w_in[31:26] == 6'b000000) w_mn = "srli";
            else if (w_in[31:26] == 6'b010000) w_mn = "srai";
          end
        endcase
      end
      7'b0011011: begin
        w_kind = K_SHW;
        case (w_f3)
          3'd0: begin w_mn = "addiw"; w_kind = K_I; end
          3'd1: if (w_f7 == 7'h00) w_mn = "slliw";
          3'd5: begin
            if (w_f7 == 7'h00) w_mn = "srliw";
            else if (w_f7 == 7'h20) w_mn = "sraiw";
          end
          default: w_mn = "";
        endcase
      end
      7'b0110011: begin
        w_kind = K_R;
        case ({w_f7, w_f3})
          10'h000: w_mn = "add";
          10'h001: w_mn = "sll";
          10'h002: w_mn = "slt";
          10'h003: w_mn = "sltu";
          10'h004: w_mn = "xor";
          10'h005: w_mn = "srl";
          10'h006: w_mn = "or";
          10'h007: w_mn = "and";
          10'h100: w_mn = "sub";
          10'h105: w_mn = "sra";
          10'h008: w_mn = "mul";
          10'h009: w_mn = "mulh";
          10'h00a: w_mn = "mulhsu";
          10'h00b: w_mn = "mulhu";
          10'h00c: w_mn = "div";
          10'h00d: w_mn = "divu";
          10'h00e: w_mn = "rem";
          10'h00f: w_mn = "remu";
          default: w_mn = "";
        endcase
      end
      7'b0111011: begin
        w_kind = K_R;
        case ({w_f7, w_f3})
          10'h000: w_mn = "addw";
          10'h001: w_mn = "sllw";
          10'h005: w_mn = "srlw";
          10'h100: w_mn = "subw";
          10'h105: w_mn = "sraw";
          10'h008: w_mn = "mulw";
          10'h00c: w_mn = "divw";
          10'h00d: w_mn = "divuw";
          10'h00e: w_mn = "remw";
          10'h00f: w_mn = "remuw";
          default: w_mn = "";
        endcase
      end
      default: w_mn = "";
    endcase
    if (w_mn == "") w_kind = K_NONE;
  end

  always_comb begin
    case (w_kind)
      K_I, K_SH, K_SHW, K_LD:
        w_imm = {{20{w_in[31]}}, w_in[31:20]};
      K_ST:
        w_imm = {{20{w_in[31]}}, w_in[31:25], w_in[11:7]};
      K_B:
        w_imm = {{20{w_in[31]}}, w_in[7],
                 w_in[30:25], w_in[11:8], 1'b0};
      K_U:
        w_imm = {w_in[31:12], 12'b0};
      K_J:
        w_imm = {{12{w_in[31]}}, w_in[19:12],
                 w_in[20], w_in[30:21], 1'b0};
      default:
        w_imm = 32'd0;
    endcase
    w_tgt = bus.addr + {{32{w_imm[31]}}, w_imm};
  end

  always_comb begin
    case (w_kind)
      K_R: bus.decoded_instr = $sformatf("%s\t%s,%s,%s",
        w_mn, rn(w_in[11:7]), rn(w_in[19:15]), rn(w_in[24:20]));
      K_I: bus.decoded_instr = $sformatf("%s\t%s,%s,%0d",
        w_mn, rn(w_in[11:7]), rn(w_in[19:15]), $signed(w_imm));
      K_SH: bus.decoded_instr = $sformatf("%s\t%s,%s,%0d",
        w_mn, rn(w_in[11:7]), rn(w_in[19:15]), w_in[25:20]);
      K_SHW: bus.decoded_instr = $sformatf("%s\t%s,%s,%0d",
        w_mn, rn(w_in[11:7]), rn(w_in[19:15]), w_in[24:20]);
      K_LD: bus.decoded_instr = $sformatf("%s\t%s,%0d(%s)",
        w_mn, rn(w_in[11:7]), $signed(w_imm), rn(w_in[19:15]));
      K_ST: bus.decoded_instr = $sformatf("%s\t%s,%0d(%s)",
        w_mn, rn(w_in[24:20]), $signed(w_imm), rn(w_in[19:15]));
      K_U: bus.decoded_instr = $sformatf("%s\t%s,0x%0h",
        w_mn, rn(w_in[11:7]), w_in[31:12]);
      K_B: bus.decoded_instr = $sformatf("%s\t%s,%s,%0h",
        w_mn, rn(w_in[19:15]), rn(w_in[24:20]), w_tgt);
      K_J: bus.decoded_instr = $sformatf("%s\t%s,%0h",
        w_mn, rn(w_in[11:7]), w_tgt);
      default: bus.decoded_instr = "unknown";
    endcase
  end

  // All-zero words are treated as idle filler, not counted.
  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= 16'd0;
    else if (bus.illegal && (w_in != 32'd0) &&
             (r_cnt != 16'hFFFF))
      r_cnt <= r_cnt + 16'd1;
  end
endmodule

// File: tb/tb_decode.sv
// tb_decode: directed checks of decode text/fields/imm
// and the illegal-instruction counter.
module tb_decode;
  logic clk;
  logic reset;
  int checks;
  int failures;

  decode_if u_if ();

  decode dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chks(input string tag, input string exp);
    string obs;
    obs = u_if.decoded_instr;
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s obs=\"%s\" exp=\"%s\"", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [63:0] a,
                     input logic [31:0] w);
    u_if.addr  = a;
    u_if.instr = w;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    u_if.addr  = 64'd0;
    u_if.instr = 32'd0;
    @(posedge clk);
    #1;
    chk("rst_cnt", 64'(u_if.illegal_cnt), 64'd0);

    // combinational vectors, reset held high throughout
    put(64'd0, 32'hFF010113);
    chk("addi_op", 64'(u_if.opcode), 64'h13);
    chk("addi_rd", 64'(u_if.rd), 64'd2);
    chk("addi_rs1", 64'(u_if.rs1), 64'd2);
    chk("addi_imm", 64'(u_if.imm), 64'hFFFFFFF0);
    chk("addi_ill", 64'(u_if.illegal), 64'd0);
    chks("addi_txt", "addi\tsp,sp,-16");

    put(64'd0, 32'h00113423);
    chk("sd_imm", 64'(u_if.imm), 64'd8);
    chk("sd_f3", 64'(u_if.funct3), 64'd3);
    chk("sd_rs2", 64'(u_if.rs2), 64'd1);
    chks("sd_txt", "sd\tra,8(sp)");

    put(64'h10000, 32'h00B50463);
    chk("beq_imm", 64'(u_if.imm), 64'd8);
    chks("beq_txt", "beq\ta0,a1,10008");

    put(64'd0, 32'h12345537);
    chk("lui_imm", 64'(u_if.imm), 64'h12345000);
    chks("lui_txt", "lui\ta0,0x12345");

    put(64'd0, 32'h02C58533);
    chk("mul_f7", 64'(u_if.funct7), 64'd1);
    chk("mul_imm", 64'(u_if.imm), 64'd0);
    chks("mul_txt", "mul\ta0,a1,a2");

    put(64'd0, 32'h43F55513);
    chk("srai_imm", 64'(u_if.imm), 64'h43F);
    chks("srai_txt", "srai\ta0,a0,63");

    put(64'd0, 32'h04001013);
    chk("slli_bad_ill", 64'(u_if.illegal), 64'd1);
    chk("slli_bad_imm", 64'(u_if.imm), 64'd0);
    chks("slli_bad_txt", "unknown");

    put(64'd0, 32'h41F5551B);
    chks("sraiw_txt", "sraiw\ta0,a0,31");

    put(64'd0, 32'hFFC42503);
    chk("lw_imm", 64'(u_if.imm), 64'hFFFFFFFC);
    chks("lw_txt", "lw\ta0,-4(s0)");

    put(64'd0, 32'hFF9FF0EF);
    chk("jal_imm", 64'(u_if.imm), 64'hFFFFFFF8);
    chks("jal_wrap", "jal\tra,fffffffffffffff8");

    put(64'h1000, 32'hFF9FF0EF);
    chks("jal_txt", "jal\tra,ff8");

    put(64'd0, 32'h41DF0FBB);
    chks("subw_txt", "subw\tt6,t5,t4");

    put(64'd0, 32'h00001297);
    chk("auipc_imm", 64'(u_if.imm), 64'h1000);
    chks("auipc_txt", "auipc\tt0,0x1");

    put(64'd0, 32'h00B52463);
    chk("br010_ill", 64'(u_if.illegal), 64'd1);
    chks("br010_txt", "unknown");

    put(64'd0, 32'h00000073);
    chk("ecall_ill", 64'(u_if.illegal), 64'd1);

    put(64'd0, 32'h0000000F);
    chk("fence_ill", 64'(u_if.illegal), 64'd1);

    @(posedge clk);
    #1;
    chk("rst_hold_cnt", 64'(u_if.illegal_cnt), 64'd0);

    // counter sequence
    reset = 1'b0;
    put(64'd0, 32'hFFFFFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("seq_ill", 64'(u_if.illegal), 64'd1);
    chks("seq_txt", "unknown");
    chk("seq_cnt3", 64'(u_if.illegal_cnt), 64'd3);

    u_if.instr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("zero_ill", 64'(u_if.illegal), 64'd1);
    chk("zero_cnt", 64'(u_if.illegal_cnt), 64'd3);

    put(64'd0, 32'hFF010113);
    @(posedge clk);
    #1;
    chk("legal_cnt", 64'(u_if.illegal_cnt), 64'd3);

    // reset wins over a concurrent illegal word
    u_if.instr = 32'hFFFFFFFF;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_cnt", 64'(u_if.illegal_cnt), 64'd0);

    repeat (65540) @(posedge clk);
    #1;
    chk("sat_cnt", 64'(u_if.illegal_cnt), 64'hFFFF);

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("final_rst", 64'(u_if.illegal_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 The module SHALL declare these ports.
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- addr  input  64  address of the instruction presented on instr.
- instr  input  32  RV64IM instruction word.
- decoded_instr  output  string  disassembly text.
- rd  output  5  destination register field.
- rs1  output  5  source register 1 field.
- rs2  output  5  source register 2 field.
- imm  output  32  sign-extended immediate.
- opcode  output  7  opcode field.
- funct3  output  3  funct3 field.
- funct7  output  7  funct7 field.
- illegal  output  1  instr is not a recognised RV64IM encoding.
- illegal_cnt  output  16  registered count of illegal instructions.
REQ-002 The module SHALL have no parameters.

Function
REQ-003 All outputs except illegal_cnt SHALL be combinational functions of instr and addr, with zero-cycle latency.
REQ-004 Raw field extraction SHALL be unconditional and independent of format:
- opcode = instr[6:0]
- rd = [11:7]
- funct3 = [14:12]
- rs1 = [19:15]
- rs2 = [24:20]
- funct7 = [31:25]
REQ-005 imm SHALL be selected by format, sign-extended from instr[31]:
- I-type (loads, OP-IMM, OP-IMM-32, JALR): instr[31:20].
- S-type: {[31:25],[11:7]}.
- B-type: {[31],[7],[30:25],[11:8],0}.
- U-type (LUI, AUIPC): {[31:12],12'b0}.
- J-type: {[31],[19:12],[20],[30:21],0}.
- R-type and illegal: 0.
REQ-006 Recognised set: full RV64I and RV64M, excluding FENCE/ECALL/EBREAK/CSR.
- LUI, AUIPC, JAL, JALR.
- BEQ/BNE/BLT/BGE/BLTU/BGEU.
- LB/LH/LW/LD/LBU/LHU/LWU, SB/SH/SW/SD.
- ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
- ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
- ADDIW/SLLIW/SRLIW/SRAIW, ADDW/SUBW/SLLW/SRLW/SRAW.
- MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, MULW/DIVW/DIVUW/REMW/REMUW.
REQ-007 Any encoding outside REQ-006 SHALL assert illegal=1 and set decoded_instr="unknown"; this includes wrong funct3/funct7 and 64-bit shifts with instr[31:26] not 000000/010000.
REQ-008 decoded_instr SHALL be the lowercase mnemonic, a TAB, then comma-separated operands with no spaces.
- Register names SHALL be ABI names: zero,ra,sp,gp,tp,t0-t2,s0,s1,a0-a7,s2-s11,t3-t6.
- No pseudo-instructions SHALL be substituted.
REQ-009 Operand forms:
- R: rd,rs1,rs2
- I-ALU: rd,rs1,imm (signed decimal)
- shifts: rd,rs1,shamt (decimal, 6-bit for 64-bit forms, 5-bit for W forms)
- loads/JALR: rd,imm(rs1)
- stores: rs2,imm(rs1)
- LUI/AUIPC: rd,0x followed by lowercase hex of instr[31:12], no leading zeros
- branches: rs1,rs2,target
- JAL: rd,target
REQ-010 target SHALL be (addr + sign-extended imm) mod 2^64, printed as lowercase hex with no prefix and no leading zeros.
REQ-011 illegal_cnt SHALL increment by 1 on each rising clk edge where illegal=1 and instr != 0, and SHALL saturate at 0xFFFF.

Reset
REQ-012 When reset=1 at a rising clk edge, illegal_cnt SHALL become 0; reset SHALL NOT affect the combinational outputs.
REQ-013 Reset asserted mid-count SHALL clear illegal_cnt at that edge, regardless of the illegal value in the same cycle.

Verification
REQ-014 instr=0xFF010113 -> opcode=0x13, rd=2, rs1=2, imm=0xFFFFFFF0, illegal=0, decoded_instr="addi\tsp,sp,-16".
REQ-015 instr=0x00113423 -> imm=8, funct3=3, decoded_instr="sd\tra,8(sp)".
REQ-016 addr=0x10000, instr=0x00B50463 -> imm=8, decoded_instr="beq\ta0,a1,10008".
REQ-017 instr=0x12345537 -> imm=0x12345000, decoded_instr="lui\ta0,0x12345"; instr=0x02C58533 -> funct7=1, decoded_instr="mul\ta0,a1,a2".
REQ-018 Sequence:
- reset for 1 cycle, then instr=0xFFFFFFFF for 3 cycles -> illegal=1, illegal_cnt=3.
- instr=0 for 2 more cycles -> illegal_cnt stays 3.
- reset pulse -> illegal_cnt=0.
